// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP); MULTICYCLE_DATAPATH_PERF_EN adds cycle/instret counters
module multicycle_datapath #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pc,
  output logic [31:0]       instruction,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] ALU_Result,
  output logic [2:0]        state,
  output logic              trap
`ifdef MULTICYCLE_DATAPATH_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  state_t            cur, nxt;
  logic [DATA_W-1:0] pc_r, a_r, b_r, alu_out, mdr;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [32];

  logic [5:0]        op, fn;
  logic [4:0]        rs, rt, rd, wb_dst;
  logic [25:0]       target;
  logic [DATA_W-1:0] simm, rd_a, rd_b, alu_res;
  logic              valid_instr;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign fn     = ir[5:0];
  assign target = ir[25:0];
  assign simm   = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign rd_a   = (rs == 5'd0) ? '0 : regs[rs];
  assign rd_b   = (rt == 5'd0) ? '0 : regs[rt];
  assign wb_dst = (op == OP_R) ? rd : rt;

  assign pc          = pc_r;
  assign instruction = ir;
  assign ALU_Result  = alu_out;
  assign state       = cur;
  assign mem_wdata   = b_r;
  assign MemRead     = (cur == S_MEM) && mem_req && !mem_we;
  assign MemWrite    = (cur == S_MEM) && mem_req && mem_we;
  assign trap        = (cur == S_TRAP) && !rst;

  // Decode legality: anything outside the supported opcode/funct set traps.
  always_comb begin
    valid_instr = 1'b0;
    case (op)
      OP_R: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: valid_instr = 1'b1;
          default:                          valid_instr = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: valid_instr = 1'b1;
      default:                             valid_instr = 1'b0;
    endcase
  end

  // ALU for R-type and addi; slt compares as signed.
  always_comb begin
    alu_res = '0;
    if (op == OP_ADDI) begin
      alu_res = a_r + simm;
    end else begin
      case (fn)
        F_ADD:   alu_res = a_r + b_r;
        F_SUB:   alu_res = a_r - b_r;
        F_AND:   alu_res = a_r & b_r;
        F_OR:    alu_res = a_r | b_r;
        F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
        default: alu_res = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Next-state and memory/register-write control.
  always_comb begin
    nxt      = cur;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_r;
    RegWrite = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) nxt = S_DECODE;
      end
      S_DECODE: nxt = valid_instr ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op)
          OP_R, OP_ADDI: nxt = S_WB;
          OP_LW, OP_SW:  nxt = S_MEM;
          default:       nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_out;
        if (mem_ack) nxt = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        RegWrite = !rst;
        nxt      = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  // Datapath registers and register file; reset abandons any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      ir      <= '0;
      a_r     <= '0;
      b_r     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (mem_ack) begin
            ir   <= mem_rdata[31:0];
            pc_r <= pc_r + PC_STEP;
          end
        end
        S_DECODE: begin
          a_r <= rd_a;
          b_r <= rd_b;
        end
        S_EXEC: begin
          case (op)
            OP_R, OP_ADDI: alu_out <= alu_res;
            OP_LW, OP_SW:  alu_out <= a_r + simm;
            OP_BEQ:        if (a_r == b_r) pc_r <= pc_r + (simm << 2);
            OP_J:          pc_r <= {pc_r[DATA_W-1:28], target, 2'b00};
            default:       ;
          endcase
        end
        S_MEM: begin
          if (mem_ack && (op == OP_LW)) mdr <= mem_rdata;
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= (op == OP_LW) ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_DATAPATH_PERF_EN
  // Cycle and retired-instruction counters; an instruction retires on its return to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if ((nxt == S_FETCH) && ((cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB)))
        instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule
